crc_pkt_buf_ctrl: RTL and testbench
===================================

Name: crc_pkt_buf_ctrl

Overview:
- Packet-buffer controller that sequences the CRC-stage data memory (`waddr`/`wdata`/`write` write port, combinational `raddr`->`rdata` read port) as a packet FIFO.
- Write side accepts words from the CRC checker. A packet is committed at end-of-packet when its CRC is good and rewound when it is bad.
- Read side streams only committed packets to the downstream MAC stage with valid/ready and a last flag.
- Sits between the CRC checker and the memory instance, and owns all memory address generation.

Parameters:
- DWIDTH, 32, data word width; equals memory width.
- AWIDTH, 10, memory address width; buffer depth DEPTH = 2**AWIDTH words.
- LF_AWIDTH, 3, address width of the internal packet-length FIFO; holds 2**LF_AWIDTH committed packets.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer word valid.
- wr_ready  out  1  controller can accept a word.
- wr_data  in  DWIDTH  producer word.
- wr_last  in  1  final word of packet.
- wr_drop  in  1  CRC bad; sampled only on the accepted wr_last beat.
- rd_valid  out  1  output word valid.
- rd_ready  in  1  consumer accepts word.
- rd_data  out  DWIDTH  output word.
- rd_last  out  1  final word of output packet.
- mem_waddr  out  AWIDTH  memory write address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_write  out  1  memory write enable.
- mem_raddr  out  AWIDTH  memory read address.
- mem_rdata  in  DWIDTH  memory read data, combinational from mem_raddr.
- pkt_count  out  LF_AWIDTH+1  committed packets not yet started on the read side.
- drop_count  out  16  dropped packets, saturating at 16'hFFFF.
- overflow  out  1  one-cycle pulse when an oversize packet is discarded.

Behaviour:
- Pointers are AWIDTH+1 bits wide; the MSB is the wrap bit.
  - wr_base: start of the packet in progress.
  - wr_cur: next write location.
  - rd_ptr: next read location.
- used = wr_cur - rd_ptr. full when used == DEPTH.
- Reset (asynchronous): all pointers 0, write FSM in W_PKT, read FSM in R_IDLE, length FIFO empty, drop_count 0.
  - Reset values of outputs: rd_valid 0, rd_last 0, mem_write 0, overflow 0, pkt_count 0, wr_ready 0.
  - wr_ready may rise on the first clock after rst deasserts.
- Reset asserted mid-packet abandons everything on both sides; no partial commit.
- Write FSM, state W_PKT:
  - wr_ready = !full && !lf_full.
  - Accept = wr_valid && wr_ready.
  - Accept without wr_last: write wr_data at wr_cur; wr_cur++.
  - Accept with wr_last && !wr_drop: write the word, then commit:
    - push length (wr_cur - wr_base + 1) into the length FIFO;
    - wr_base <= wr_cur + 1; wr_cur <= wr_cur + 1.
  - Accept with wr_last && wr_drop: no memory write (mem_write 0); wr_cur <= wr_base; drop_count++.
  - If full && wr_cur - wr_base == DEPTH (packet alone fills the buffer): wr_cur <= wr_base; overflow pulse; drop_count++; go to W_DISCARD.
- Write FSM, state W_DISCARD:
  - wr_ready = 1; words are accepted and not written.
  - On the accepted wr_last beat, return to W_PKT.
- Memory write port, combinational:
  - mem_waddr = wr_cur[AWIDTH-1:0].
  - mem_wdata = wr_data.
  - mem_write = accept && state == W_PKT && !(wr_last && wr_drop).
- Length FIFO:
  - Synchronous, registered, width AWIDTH+1.
  - pkt_count equals its occupancy.
  - lf_full blocks wr_ready in W_PKT.
- Read FSM, state R_IDLE:
  - rd_valid 0.
  - If the length FIFO is not empty: pop into rd_remain and go to R_SEND next cycle.
- Read FSM, state R_SEND:
  - rd_valid = 1.
  - mem_raddr = rd_ptr[AWIDTH-1:0]; rd_data = mem_rdata, same-cycle.
  - rd_last = (rd_remain == 1).
  - On rd_valid && rd_ready: rd_ptr++; rd_remain--. If rd_last, go to R_IDLE.
  - One idle cycle between packets is required behaviour.
- rd_valid stays high and rd_data stays stable while rd_ready is low (AXI-style).
- Simultaneous read and write in the same cycle: occupancy is computed from registered pointers, so space freed by a read becomes visible to wr_ready on the next cycle.
- A commit in the same cycle as a length FIFO pop is legal; occupancy is unchanged.
- mem_raddr = rd_ptr[AWIDTH-1:0] also in R_IDLE (don't-care data).

Test Plan:
- Single-word packet: wr 0xA5A5A5A5 with last, drop=0.
  - Required: pkt_count 1 next cycle.
  - Required: rd_valid two cycles later with rd_data 0xA5A5A5A5, rd_last 1.
- 4-word packet 0x1..0x4, good CRC, rd_ready held 0 for 3 cycles.
  - Required: rd_data stays 0x1 during the stall.
  - Required: then 0x1..0x4 in order, rd_last only on 0x4.
  - Required: mem_waddr 0..3.
- Packet 0x10..0x12 with drop on last, then good packet 0x20,0x21.
  - Required: drop_count 1.
  - Required: 0x20 written at address 0, and only 0x20,0x21 read out.
- AWIDTH=3: 9-word packet.
  - Required: overflow pulses when 8 words are held, and drop_count 1.
  - Required: remaining word accepted with wr_ready 1.
  - Required: next 2-word packet starts at address 0 and reads out correctly.
- Wrap-around, AWIDTH=3: stream five 3-word good packets with rd_ready 1.
  - Required: addresses wrap 7->0.
  - Required: all 15 words out in order.
  - Required: wr_ready deasserts exactly when used == 8.
- Assert rst mid-read and mid-write.
  - Required: rd_valid, mem_write and pkt_count go to 0 immediately.
  - Required: a subsequent packet starts at address 0.

Source files
------------

// File: rtl/crc_pkt_buf_ctrl.sv
// Packet FIFO controller for the CRC-stage data memory: commits good packets,
// rewinds bad or oversize ones, and streams committed packets downstream.
module crc_pkt_buf_ctrl #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 10,
  parameter int unsigned LF_AWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DWIDTH-1:0]    wr_data,
  input  logic                 wr_last,
  input  logic                 wr_drop,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DWIDTH-1:0]    rd_data,
  output logic                 rd_last,
  output logic [AWIDTH-1:0]    mem_waddr,
  output logic [DWIDTH-1:0]    mem_wdata,
  output logic                 mem_write,
  output logic [AWIDTH-1:0]    mem_raddr,
  input  logic [DWIDTH-1:0]    mem_rdata,
  output logic [LF_AWIDTH:0]   pkt_count,
  output logic [15:0]          drop_count,
  output logic                 overflow
);

  localparam int unsigned        LF_DEPTH = 2**LF_AWIDTH;
  localparam logic [AWIDTH:0]    DEPTH_P  = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]    PTR_ONE  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [LF_AWIDTH:0] LF_FULL  = {1'b1, {LF_AWIDTH{1'b0}}};
  localparam logic [LF_AWIDTH:0] LF_ONE   = {{LF_AWIDTH{1'b0}}, 1'b1};

  typedef enum logic {W_PKT = 1'b0, W_DISCARD = 1'b1} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rstate_e;

  wstate_e          wstate_q, wstate_d;
  rstate_e          rstate_q, rstate_d;
  logic [AWIDTH:0]  wr_base_q, wr_base_d;
  logic [AWIDTH:0]  wr_cur_q, wr_cur_d;
  logic [AWIDTH:0]  rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]  rd_remain_q, rd_remain_d;
  logic [LF_AWIDTH:0] lf_wptr_q, lf_wptr_d;
  logic [LF_AWIDTH:0] lf_rptr_q, lf_rptr_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             rdy_en_q, rdy_en_d;

  logic [AWIDTH:0]  lf_mem [LF_DEPTH];

  logic [AWIDTH:0]    used;
  logic [AWIDTH:0]    pkt_len;
  logic [LF_AWIDTH:0] lf_count;
  logic               full;
  logic               lf_full;
  logic               lf_empty;
  logic               lf_push;
  logic               lf_pop;
  logic               wr_accept;
  logic [15:0]        drop_inc;

  assign used     = wr_cur_q - rd_ptr_q;
  assign full     = (used == DEPTH_P);
  assign pkt_len  = wr_cur_q - wr_base_q;
  assign lf_count = lf_wptr_q - lf_rptr_q;
  assign lf_full  = (lf_count == LF_FULL);
  assign lf_empty = (lf_count == '0);
  assign drop_inc = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + 16'd1;

  assign mem_waddr  = wr_cur_q[AWIDTH-1:0];
  assign mem_wdata  = wr_data;
  assign mem_raddr  = rd_ptr_q[AWIDTH-1:0];
  assign rd_data    = mem_rdata;
  assign pkt_count  = lf_count;
  assign drop_count = drop_cnt_q;

  // rdy_en_q keeps wr_ready low until the first clock after reset release
  assign rdy_en_d = 1'b1;

  always_comb begin
    wstate_d   = wstate_q;
    wr_base_d  = wr_base_q;
    wr_cur_d   = wr_cur_q;
    drop_cnt_d = drop_cnt_q;
    wr_ready   = 1'b0;
    wr_accept  = 1'b0;
    mem_write  = 1'b0;
    overflow   = 1'b0;
    lf_push    = 1'b0;
    case (wstate_q)
      W_PKT: begin
        wr_ready  = rdy_en_q && !full && !lf_full;
        wr_accept = wr_valid && wr_ready;
        if (full && pkt_len == DEPTH_P) begin
          overflow   = 1'b1;
          wr_cur_d   = wr_base_q;
          drop_cnt_d = drop_inc;
          wstate_d   = W_DISCARD;
        end else if (wr_accept) begin
          if (!wr_last) begin
            mem_write = 1'b1;
            wr_cur_d  = wr_cur_q + PTR_ONE;
          end else if (!wr_drop) begin
            mem_write = 1'b1;
            lf_push   = 1'b1;
            wr_cur_d  = wr_cur_q + PTR_ONE;
            wr_base_d = wr_cur_q + PTR_ONE;
          end else begin
            wr_cur_d   = wr_base_q;
            drop_cnt_d = drop_inc;
          end
        end
      end
      W_DISCARD: begin
        wr_ready  = 1'b1;
        wr_accept = wr_valid;
        if (wr_accept && wr_last) begin
          wstate_d = W_PKT;
        end
      end
    endcase
  end

  always_comb begin
    rstate_d    = rstate_q;
    rd_ptr_d    = rd_ptr_q;
    rd_remain_d = rd_remain_q;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    lf_pop      = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (!lf_empty) begin
          lf_pop      = 1'b1;
          rd_remain_d = lf_mem[lf_rptr_q[LF_AWIDTH-1:0]];
          rstate_d    = R_SEND;
        end
      end
      R_SEND: begin
        rd_valid = 1'b1;
        rd_last  = (rd_remain_q == PTR_ONE);
        if (rd_ready) begin
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          rd_remain_d = rd_remain_q - PTR_ONE;
          if (rd_last) begin
            rstate_d = R_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    lf_wptr_d = lf_push ? lf_wptr_q + LF_ONE : lf_wptr_q;
    lf_rptr_d = lf_pop  ? lf_rptr_q + LF_ONE : lf_rptr_q;
  end

  always_ff @(posedge clk) begin
    if (lf_push) begin
      lf_mem[lf_wptr_q[LF_AWIDTH-1:0]] <= pkt_len + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q    <= W_PKT;
      rstate_q    <= R_IDLE;
      wr_base_q   <= '0;
      wr_cur_q    <= '0;
      rd_ptr_q    <= '0;
      rd_remain_q <= '0;
      lf_wptr_q   <= '0;
      lf_rptr_q   <= '0;
      drop_cnt_q  <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      wr_base_q   <= wr_base_d;
      wr_cur_q    <= wr_cur_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_remain_q <= rd_remain_d;
      lf_wptr_q   <= lf_wptr_d;
      lf_rptr_q   <= lf_rptr_d;
      drop_cnt_q  <= drop_cnt_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_crc_pkt_buf_ctrl.sv
// Bench for crc_pkt_buf_ctrl: packet-queue reference model checked every cycle,
// plus directed packets with hand-computed expectations.
module tb_crc_pkt_buf_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int LW    = 2;
  localparam int DEPTH = 8;
  localparam int LFD   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_last = 1'b0;
  logic          wr_drop = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_valid, rd_last, mem_write, overflow;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [LW:0]   pkt_count;
  logic [15:0]   drop_count;

  int total = 0;
  int bad = 0;
  int ovf_seen = 0;
  logic [DW-1:0] got[$];
  logic          got_last[$];

  always #5 clk = ~clk;

  crc_pkt_buf_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .LF_AWIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_last(wr_last), .wr_drop(wr_drop),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow)
  );

  logic [DW-1:0] bmem [DEPTH];
  always @(posedge clk) if (mem_write) bmem[mem_waddr] <= mem_wdata;
  assign mem_rdata = bmem[mem_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer contents as word/packet queues and counts.
  bit alive, discarding, sending;
  int used, cur_len, wcur, rptr, drops;
  logic [DW-1:0] pw[$];
  logic [DW-1:0] cq[$];
  logic [DW-1:0] sq[$];
  int lq[$];

  always @(negedge clk) begin : cmp
    bit e_ready, acc, e_mw, e_ovf;
    int n;
    if (rst) begin
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_last", rd_last, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_drop_count", drop_count, 0);
      alive = 0; discarding = 0; sending = 0;
      used = 0; cur_len = 0; wcur = 0; rptr = 0; drops = 0;
      pw.delete(); cq.delete(); sq.delete(); lq.delete();
    end else begin
      e_ready = alive && (discarding || (used < DEPTH && lq.size() < LFD));
      acc     = wr_valid && e_ready;
      e_mw    = acc && !discarding && !(wr_last && wr_drop);
      e_ovf   = !discarding && cur_len == DEPTH;
      chk("wr_ready", wr_ready, e_ready);
      chk("mem_write", mem_write, e_mw);
      chk("overflow", overflow, e_ovf);
      chk("mem_waddr", mem_waddr, wcur % DEPTH);
      if (e_mw) chk("mem_wdata", mem_wdata, wr_data);
      chk("rd_valid", rd_valid, sending);
      chk("rd_last", rd_last, sending && sq.size() == 1);
      chk("mem_raddr", mem_raddr, rptr % DEPTH);
      if (sending) chk("rd_data", rd_data, sq[0]);
      chk("pkt_count", pkt_count, lq.size());
      chk("drop_count", drop_count, drops);
      if (sending) begin
        if (rd_ready) begin
          void'(sq.pop_front());
          used--; rptr++;
          if (sq.size() == 0) sending = 0;
        end
      end else if (lq.size() > 0) begin
        n = lq.pop_front();
        repeat (n) sq.push_back(cq.pop_front());
        sending = 1;
      end
      if (discarding) begin
        if (acc && wr_last) discarding = 0;
      end else if (e_ovf) begin
        used -= cur_len; wcur -= cur_len; cur_len = 0; pw.delete();
        if (drops < 65535) drops++;
        discarding = 1;
      end else if (acc) begin
        if (wr_last && wr_drop) begin
          used -= cur_len; wcur -= cur_len; cur_len = 0; pw.delete();
          if (drops < 65535) drops++;
        end else begin
          pw.push_back(wr_data);
          used++; wcur++; cur_len++;
          if (wr_last) begin
            lq.push_back(cur_len);
            foreach (pw[i]) cq.push_back(pw[i]);
            pw.delete();
            cur_len = 0;
          end
        end
      end
      alive = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      got.push_back(rd_data);
      got_last.push_back(rd_last);
    end
    if (!rst && overflow) ovf_seen++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_drop = 1'b0;
    tick; tick;
    rst = 1'b0;
    got.delete(); got_last.delete(); ovf_seen = 0;
    tick;
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n, input bit drop,
                          input bit chk_addr, input int addr0);
    for (int i = 0; i < n; i++) begin
      int waitc;
      bit acc;
      waitc = 0; acc = 0;
      wr_valid = 1'b1; wr_data = base + i;
      wr_last = (i == n - 1); wr_drop = drop && (i == n - 1);
      while (!acc) begin
        @(negedge clk);
        acc = wr_ready;
        if (acc && chk_addr) begin
          chk("lit_waddr", mem_waddr, (addr0 + i) % DEPTH);
          chk("lit_mem_write", mem_write, !(drop && i == n - 1));
        end
        tick;
        if (!acc) begin
          waitc++;
          if (waitc > 100) begin
            chk("accept_timeout", 0, 1);
            acc = 1;
          end
        end
      end
    end
    wr_valid = 1'b0; wr_last = 1'b0; wr_drop = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 200) begin
      tick; c++;
    end
    chk("words_out", got.size(), n);
  endtask

  initial begin
    tick; tick;
    chk("lit_rst_rd_valid", rd_valid, 0);
    chk("lit_rst_wr_ready", wr_ready, 0);
    chk("lit_rst_pkt_count", pkt_count, 0);
    rst = 1'b0;
    chk("lit_ready_hold", wr_ready, 0);
    tick;
    chk("lit_ready_rise", wr_ready, 1);

    // single-word packet
    rd_ready = 1'b1;
    send_pkt(32'hA5A5A5A5, 1, 0, 1, 0);
    chk("lit_pkt_count1", pkt_count, 1);
    tick;
    chk("lit_single_valid", rd_valid, 1);
    chk("lit_single_data", rd_data, 32'hA5A5A5A5);
    chk("lit_single_last", rd_last, 1);
    tick; tick;

    // 4-word packet with a 3-cycle stall
    do_reset;
    rd_ready = 1'b0;
    send_pkt(32'h1, 4, 0, 1, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("lit_stall_valid", rd_valid, 1);
      chk("lit_stall_data", rd_data, 32'h1);
      tick;
    end
    rd_ready = 1'b1;
    wait_words(4);
    for (int i = 0; i < 4; i++) begin
      chk("lit_four_data", got[i], i + 1);
      chk("lit_four_last", got_last[i], i == 3);
    end

    // dropped packet then good packet
    do_reset;
    rd_ready = 1'b1;
    send_pkt(32'h10, 3, 1, 1, 0);
    tick;
    chk("lit_drop_count", drop_count, 1);
    chk("lit_drop_pkts", pkt_count, 0);
    send_pkt(32'h20, 2, 0, 1, 0);
    wait_words(2);
    tick; tick; tick;
    chk("lit_drop_nout", got.size(), 2);
    chk("lit_drop_w0", got[0], 32'h20);
    chk("lit_drop_w1", got[1], 32'h21);

    // oversize packet
    do_reset;
    rd_ready = 1'b0;
    send_pkt(32'h30, 9, 0, 0, 0);
    tick;
    chk("lit_ovf_seen", ovf_seen, 1);
    chk("lit_ovf_drops", drop_count, 1);
    chk("lit_ovf_pkts", pkt_count, 0);
    rd_ready = 1'b1;
    send_pkt(32'h40, 2, 0, 1, 0);
    wait_words(2);
    chk("lit_ovf_w0", got[0], 32'h40);
    chk("lit_ovf_w1", got[1], 32'h41);

    // wrap-around stream, then fill to full
    do_reset;
    rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_pkt(32'((k + 1) << 8), 3, 0, 1, 3 * k);
    wait_words(15);
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 3; j++)
        chk("lit_wrap_data", got[3 * k + j], ((k + 1) << 8) + j);
    tick; tick;
    rd_ready = 1'b0;
    send_pkt(32'hA00, 3, 0, 1, 7);
    send_pkt(32'hB00, 3, 0, 1, 2);
    send_pkt(32'hC00, 2, 0, 1, 5);
    chk("lit_full_ready", wr_ready, 0);
    chk("lit_full_pkts", pkt_count, 2);
    rd_ready = 1'b1;
    wait_words(23);
    chk("lit_full_first", got[15], 32'hA00);
    chk("lit_full_lastw", got[22], 32'hC01);

    // length FIFO full
    do_reset;
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_pkt(32'hD0 + i, 1, 0, 1, i);
    chk("lit_lf_pkts", pkt_count, 4);
    chk("lit_lf_ready", wr_ready, 0);
    rd_ready = 1'b1;
    wait_words(5);
    for (int i = 0; i < 5; i++) chk("lit_lf_data", got[i], 32'hD0 + i);

    // asynchronous reset mid-read and mid-write
    do_reset;
    rd_ready = 1'b0;
    send_pkt(32'h60, 2, 0, 1, 0);
    send_pkt(32'h70, 1, 0, 1, 2);
    tick;
    wr_valid = 1'b1; wr_data = 32'h71; wr_last = 1'b0;
    #1;
    chk("lit_pre_mem_write", mem_write, 1);
    chk("lit_pre_rd_valid", rd_valid, 1);
    chk("lit_pre_pkt_count", pkt_count, 1);
    #1 rst = 1'b1;
    #1;
    chk("lit_arst_rd_valid", rd_valid, 0);
    chk("lit_arst_mem_write", mem_write, 0);
    chk("lit_arst_pkt_count", pkt_count, 0);
    wr_valid = 1'b0;
    tick; tick;
    rst = 1'b0;
    got.delete(); got_last.delete();
    tick;
    rd_ready = 1'b1;
    send_pkt(32'h80, 2, 0, 1, 0);
    wait_words(2);
    chk("lit_post_w0", got[0], 32'h80);
    chk("lit_post_w1", got[1], 32'h81);
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
